interrupt_controller: RTL

- Multi-source interrupt controller in front of the CPU control unit.
- Latches rising edges on N_SRC interrupt lines (timer, I/O, ...), applies a per-source enable mask and picks one source.
- Presents the selected source's 10-bit subroutine address to the CPU and sequences the request/acknowledge/return handshake, one interrupt in service at a time.

---
 rtl/interrupt_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Multi-source interrupt controller sitting in front of the CPU control unit.
// It latches rising edges on the raw interrupt lines into pending flags and
// masks them with a per-source enable register. One eligible source is
// granted and its subroutine address is presented to the CPU. The controller
// then sequences the request / acknowledge / return handshake, with only one
// interrupt in service at a time.
//
// Optional feature (macro IRQ_ROUND_ROBIN_EN):
//   defined   : round-robin arbitration. The search starts one past the last
//               acknowledged source and wraps around.
//   undefined : fixed priority, where the lowest index wins. No pointer
//               register is built.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   irq_src        in   raw interrupt lines (N_SRC), a rising edge requests
//   en_we          in   load en_in into the enable register
//   en_in          in   new enable mask (N_SRC)
//   int_ack        in   CPU has taken the vector
//   s_finished     in   CPU has executed return-from-interrupt
//   int_req        out  interrupt request, high only in REQ
//   dir_out        out  10-bit subroutine address of the granted source
//   s_interruption out  high in REQ and SERVICE
//   active_id      out  index of the granted / in-service source (ID_W)
//   pending        out  latched pending flags (N_SRC)
//   en_out         out  current enable register (N_SRC)
// ---------------------------------------------------------------------------
module interrupt_controller #(
  parameter int          N_SRC      = 4,
  parameter int          ID_W       = 2,
  parameter logic [9:0]  VEC_BASE   = 10'b1000000000,
  parameter logic [9:0]  VEC_STRIDE = 10'd16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              en_we,
  input  logic [N_SRC-1:0]  en_in,
  input  logic              int_ack,
  input  logic              s_finished,
  output logic              int_req,
  output logic [9:0]        dir_out,
  output logic              s_interruption,
  output logic [ID_W-1:0]   active_id,
  output logic [N_SRC-1:0]  pending,
  output logic [N_SRC-1:0]  en_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   en_q, en_d;
  logic [N_SRC-1:0]   prev_q, prev_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;

  logic [N_SRC-1:0]   elig;
  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   clr;
  logic [ID_W-1:0]    winner;
  logic [9:0]         vec_addr;
  logic               ack_taken;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]    last_q, last_d;
  int                 rr_idx;
  logic               rr_found;
`endif

  assign elig      = pending_q & en_q;
  assign rise      = irq_src & ~prev_q;
  assign ack_taken = (state_q == REQ) && int_ack;

  // Only the granted source is cleared on acknowledge. A rising edge in the
  // same cycle is OR-ed in afterwards, so the set wins over the clear.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_taken && (active_id_q == ID_W'(i));
    end
  end

  always_comb begin
    pending_d = (pending_q & ~clr) | rise;
    prev_d    = irq_src;
    en_d      = en_we ? en_in : en_q;
  end

`ifdef IRQ_ROUND_ROBIN_EN
  // Start one past the last acknowledged source and take the first eligible
  // source while wrapping. Because the pointer resets to N_SRC-1, the first
  // search begins at source 0.
  always_comb begin
    winner   = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      rr_idx = (int'(last_q) + k) % N_SRC;
      if (!rr_found && elig[rr_idx]) begin
        winner   = ID_W'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (ack_taken) begin
      last_d = active_id_q;
    end
  end
`else
  // Fixed priority. Scanning downward lets the lowest eligible index be the
  // last one assigned.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = ID_W'(i);
      end
    end
  end
`endif

  // The handshake FSM. The winner is captured on the IDLE->REQ edge and held
  // through SERVICE, so the vector stays stable until the return.
  // s_finished is only honoured in SERVICE. Because of that, ack together
  // with finish in REQ only takes the ack.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    unique case (state_q)
      IDLE: begin
        if (elig != '0) begin
          state_d     = REQ;
          active_id_d = winner;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (s_finished) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      en_q        <= '1;
      prev_q      <= '0;
      active_id_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      en_q        <= en_d;
      prev_q      <= prev_d;
      active_id_q <= active_id_d;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= ID_W'(N_SRC - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // The vector wraps modulo 2^10 by construction of the 10-bit arithmetic.
  assign vec_addr = VEC_BASE + (10'(active_id_q) * VEC_STRIDE);

  always_comb begin
    int_req        = (state_q == REQ);
    s_interruption = (state_q != IDLE);
    dir_out        = (state_q == IDLE) ? 10'd0 : vec_addr;
  end

  assign active_id = active_id_q;
  assign pending   = pending_q;
  assign en_out    = en_q;

endmodule
